rx_byte_aligner_nlane: RTL

RX_BYTE_ALIGNER_NLANE -- requirements
Module: rx_byte_aligner_nlane

---
 rtl/csi_rx_pkg.sv | 13 +
 rtl/rx_lane_aligner.sv | 94 +++++++++
 rtl/rx_byte_aligner_nlane.sv | 49 ++++
 3 files changed

// File: rtl/csi_rx_pkg.sv
// csi_rx_pkg: shared FSM encoding, widths and sync-match helper for the CSI-2 RX byte aligner
package csi_rx_pkg;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;
  localparam int BYTE_W = 8;
  localparam int OFF_W = 3;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {ST_HUNT, ST_LOCKED, ST_FAIL} lane_st_e;
  function automatic logic one_bit_diff(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a ^ b;
    return d != 8'd0 && (d & (d - 8'd1)) == 8'd0;
  endfunction
endpackage

// File: rtl/rx_lane_aligner.sv
// rx_lane_aligner: single D-PHY lane sync hunt, bit-offset lock and aligned byte output
//   i_clk/i_rst_n : byte clock, async active-low reset
//   i_active      : lane HS-active qualifier; low restarts the hunt
//   i_byte        : raw deserialised byte, bit 0 earliest
//   o_byte/o_valid: aligned byte and its valid
//   o_valid_nxt   : value o_valid takes at the next edge (feeds the all-locked register)
//   o_err_hs      : pulse when lock came from a 1-bit-error sync
//   o_err_sync    : pulse when the hunt timed out
module rx_lane_aligner import csi_rx_pkg::*; #(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int TIMEOUT = 16,
  parameter bit ALLOW_1BIT_ERR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_active,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_valid,
  output logic              o_valid_nxt,
  output logic              o_err_hs,
  output logic              o_err_sync
);
  lane_st_e          r_st, w_st_nxt;
  logic [BYTE_W-1:0] r_prev, r_byte;
  logic [OFF_W-1:0]  r_off, w_ex_off, w_e1_off, w_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       w_win;
  logic              r_valid, r_err_hs, r_err_sync;
  logic              w_ex_hit, w_e1_hit, w_hit, w_hunt, w_timeout;
  assign w_win = {i_byte, r_prev};
  // Scan downwards so the lowest matching offset is the one left standing.
  always_comb begin
    w_ex_hit = 1'b0;
    w_ex_off = '0;
    w_e1_hit = 1'b0;
    w_e1_off = '0;
    for (int k = 7; k >= 0; k--) begin
      if (w_win[k +: 8] == SYNC_BYTE) begin
        w_ex_hit = 1'b1;
        w_ex_off = OFF_W'(k);
      end
      if (ALLOW_1BIT_ERR && one_bit_diff(w_win[k +: 8], SYNC_BYTE)) begin
        w_e1_hit = 1'b1;
        w_e1_off = OFF_W'(k);
      end
    end
  end
  assign w_hit       = w_ex_hit | w_e1_hit;
  assign w_sel       = w_ex_hit ? w_ex_off : w_e1_off;
  assign w_hunt      = r_st == ST_HUNT;
  assign w_timeout   = r_cnt == CNT_W'(TIMEOUT - 1);
  assign o_valid_nxt = i_active && r_st == ST_LOCKED;
  // A match on the timeout cycle still locks: hit is tested before timeout.
  always_comb begin
    w_st_nxt = r_st;
    if (!i_active) w_st_nxt = ST_HUNT;
    else if (w_hunt && w_hit) w_st_nxt = ST_LOCKED;
    else if (w_hunt && w_timeout) w_st_nxt = ST_FAIL;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_st <= ST_HUNT;
    else r_st <= w_st_nxt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev     <= '0;
      r_byte     <= '0;
      r_off      <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_err_hs   <= 1'b0;
      r_err_sync <= 1'b0;
    end else if (!i_active) begin
      r_prev     <= '0;
      r_off      <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_err_hs   <= 1'b0;
      r_err_sync <= 1'b0;
    end else begin
      r_prev     <= i_byte;
      r_cnt      <= w_hunt ? r_cnt + CNT_W'(1) : r_cnt;
      r_off      <= (w_hunt && w_hit) ? w_sel : r_off;
      r_byte     <= (r_st == ST_LOCKED) ? w_win[r_off +: 8] : r_byte;
      r_valid    <= o_valid_nxt;
      r_err_hs   <= w_hunt && w_hit && !w_ex_hit;
      r_err_sync <= w_hunt && !w_hit && w_timeout;
    end
  end
  assign o_byte     = r_byte;
  assign o_valid    = r_valid;
  assign o_err_hs   = r_err_hs;
  assign o_err_sync = r_err_sync;
endmodule

// File: rtl/rx_byte_aligner_nlane.sv
// rx_byte_aligner_nlane: LANES independent D-PHY byte aligners plus a registered all-locked flag
//   clk_i/reset_n_i   : byte clock, async active-low reset
//   lane_active_i     : per-lane HS-active qualifier
//   byte_i/byte_o     : raw / aligned bytes, lane k at [8k+7:8k]
//   byte_valid_o      : per-lane aligned-data valid
//   err_sot_hs_o      : per-lane 1-bit-error sync lock pulse
//   err_sot_sync_hs_o : per-lane hunt timeout pulse
//   all_locked_o      : every active lane valid and at least one lane active
module rx_byte_aligner_nlane import csi_rx_pkg::*; #(
  parameter int LANES = 2,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int TIMEOUT = 16,
  parameter bit ALLOW_1BIT_ERR = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [LANES-1:0]        lane_active_i,
  input  logic [BYTE_W*LANES-1:0] byte_i,
  output logic [BYTE_W*LANES-1:0] byte_o,
  output logic [LANES-1:0]        byte_valid_o,
  output logic [LANES-1:0]        err_sot_hs_o,
  output logic [LANES-1:0]        err_sot_sync_hs_o,
  output logic                    all_locked_o
);
  logic [LANES-1:0] w_valid_nxt;
  logic             r_all;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rx_lane_aligner #(
      .SYNC_BYTE(SYNC_BYTE),
      .TIMEOUT(TIMEOUT),
      .ALLOW_1BIT_ERR(ALLOW_1BIT_ERR)
    ) u_lane (
      .i_clk(clk_i),
      .i_rst_n(reset_n_i),
      .i_active(lane_active_i[g]),
      .i_byte(byte_i[BYTE_W*g +: BYTE_W]),
      .o_byte(byte_o[BYTE_W*g +: BYTE_W]),
      .o_valid(byte_valid_o[g]),
      .o_valid_nxt(w_valid_nxt[g]),
      .o_err_hs(err_sot_hs_o[g]),
      .o_err_sync(err_sot_sync_hs_o[g])
    );
  end
  // Built from next-edge valids so it moves on the same edge as byte_valid_o.
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_all <= 1'b0;
    else r_all <= |lane_active_i && &(~lane_active_i | w_valid_nxt);
  assign all_locked_o = r_all;
endmodule
